// File: rtl/rf_hazard_ctl_pkg.sv
// Shared definitions for the register-fetch hazard controller: forward
// select codes, multiply/divide state encoding and the tracking-slot layout.
package mips789_defs;

  localparam int REG_W    = 5;
  localparam int MD_CNT_W = 6;
  localparam int FW_W     = 3;

  localparam logic [FW_W-1:0] FW_NOP = 3'b000;
  localparam logic [FW_W-1:0] FW_ALU = 3'b001;
  localparam logic [FW_W-1:0] FW_MEM = 3'b010;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } slot_t;

  function automatic slot_t slot_bubble();
    slot_t s;
    s.valid   = 1'b0;
    s.dest    = 5'd0;
    s.is_load = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/rf_hazard_ctl_fwd_sel.sv
// Per-operand forward select: compares one source index against the EX and
// MEM destination slots and reports a load hit in EX (which must stall).
module fwd_sel
  import mips789_defs::*;
(
  input  logic [REG_W-1:0] i_idx,
  input  logic             i_uses,
  input  slot_t            i_ex_slot,
  input  slot_t            i_mem_slot,
  output logic [FW_W-1:0]  o_sel,
  output logic             o_load_hit
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_unused_mem_load;

  assign w_ex_hit  = i_uses && (i_idx != 5'd0) && i_ex_slot.valid  && (i_ex_slot.dest  == i_idx);
  assign w_mem_hit = i_uses && (i_idx != 5'd0) && i_mem_slot.valid && (i_mem_slot.dest == i_idx);
  assign w_unused_mem_load = i_mem_slot.is_load;

  // EX has priority; a load in EX cannot forward yet, so it raises a hit instead.
  always_comb begin
    o_sel      = FW_NOP;
    o_load_hit = 1'b0;
    if (w_ex_hit) begin
      if (i_ex_slot.is_load) begin
        o_load_hit = 1'b1;
      end else begin
        o_sel = FW_ALU;
      end
    end else if (w_mem_hit) begin
      o_sel = FW_MEM;
    end else begin
      o_sel = FW_NOP;
    end
  end

endmodule

// File: rtl/rf_hazard_ctl.sv
// Register-fetch hazard controller: forwarding selects, load-use stall and,
// when RF_HAZARD_MULDIV_EN is defined, the multiply/divide interlock.
module rf_hazard_ctl
  import mips789_defs::*;
#(
  parameter int MD_CYCLES = 33
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             pause,
  input  logic             flush_i,
  input  logic [REG_W-1:0] rs_n_i,
  input  logic [REG_W-1:0] rt_n_i,
  input  logic [REG_W-1:0] rd_index_i,
  input  logic             uses_rs_i,
  input  logic             uses_rt_i,
  input  logic             wr_en_i,
  input  logic             is_load_i,
  input  logic             md_start_i,
  input  logic             md_read_i,
  output logic [FW_W-1:0]  fw_cmp_rs_o,
  output logic [FW_W-1:0]  fw_cmp_rt_o,
  output logic             stall_o,
  output logic             ex_bubble_o,
  output logic             md_busy_o
);

  slot_t r_ex_slot;
  slot_t r_mem_slot;
  logic  w_rs_load_hit;
  logic  w_rt_load_hit;
  logic  w_md_stall;
  logic  w_stall;

  fwd_sel u_fwd_rs (
    .i_idx      (rs_n_i),
    .i_uses     (uses_rs_i),
    .i_ex_slot  (r_ex_slot),
    .i_mem_slot (r_mem_slot),
    .o_sel      (fw_cmp_rs_o),
    .o_load_hit (w_rs_load_hit)
  );

  fwd_sel u_fwd_rt (
    .i_idx      (rt_n_i),
    .i_uses     (uses_rt_i),
    .i_ex_slot  (r_ex_slot),
    .i_mem_slot (r_mem_slot),
    .o_sel      (fw_cmp_rt_o),
    .o_load_hit (w_rt_load_hit)
  );

  // A flush squashes the RF instruction, so no stall cause survives it.
  always_comb begin
    w_stall = 1'b0;
    if (flush_i) begin
      w_stall = 1'b0;
    end else begin
      w_stall = w_rs_load_hit | w_rt_load_hit | w_md_stall;
    end
  end

  assign stall_o     = w_stall;
  assign ex_bubble_o = w_stall | flush_i;

  // Destination tracking: the RF instruction enters EX unless it is held or squashed.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_ex_slot  <= slot_bubble();
      r_mem_slot <= slot_bubble();
    end else if (!pause) begin
      r_mem_slot <= r_ex_slot;
      if (w_stall || flush_i) begin
        r_ex_slot <= slot_bubble();
      end else begin
        r_ex_slot.valid   <= wr_en_i;
        r_ex_slot.dest    <= rd_index_i;
        r_ex_slot.is_load <= is_load_i;
      end
    end
  end

`ifdef RF_HAZARD_MULDIV_EN
  localparam logic [MD_CNT_W-1:0] LP_MD_CYCLES = MD_CNT_W'(MD_CYCLES);

  md_state_t           r_md_state;
  logic [MD_CNT_W-1:0] r_md_cnt;

  assign w_md_stall = (r_md_state == MD_BUSY) && (md_read_i || md_start_i);
  assign md_busy_o  = (r_md_state == MD_BUSY);

  // Occupancy countdown; reset abandons a running operation, flush does not.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_md_state <= MD_IDLE;
      r_md_cnt   <= 6'd0;
    end else if (!pause) begin
      case (r_md_state)
        MD_IDLE: begin
          if (md_start_i && !w_stall && !flush_i) begin
            r_md_state <= MD_BUSY;
            r_md_cnt   <= LP_MD_CYCLES;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt == 6'd1) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= 6'd0;
          end else begin
            r_md_cnt <= r_md_cnt - 6'd1;
          end
        end
        default: begin
          r_md_state <= MD_IDLE;
          r_md_cnt   <= 6'd0;
        end
      endcase
    end
  end
`else
  logic w_unused_md;

  assign w_unused_md = &{1'b0, md_start_i, md_read_i, MD_CYCLES[0]};
  assign w_md_stall  = 1'b0;
  assign md_busy_o   = 1'b0;
`endif

endmodule
